// File: rtl/bus_datapath_seq.sv
// Shared-bus datapath with a register file, Y and Z registers, and an ALU.
// A T3-T5 step sequencer runs "op Rc, Ra, Rb" by itself after start is seen
// in IDLE. A direct load port writes a register while the sequencer is idle.
module bus_datapath_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [SEL_W-1:0]  ra,
  input  logic [SEL_W-1:0]  rb,
  input  logic [SEL_W-1:0]  rc,
  input  logic              load_en,
  input  logic [SEL_W-1:0]  load_sel,
  input  logic [DATA_W-1:0] load_data,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] zhigh,
  output logic [DATA_W-1:0] zlow,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T3   = 2'd1,
    T4   = 2'd2,
    T5   = 2'd3
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  state_t state_q, state_d;

  // Operation latched when the sequencer leaves IDLE.
  logic [1:0]        op_q;
  logic [SEL_W-1:0]  ra_q, rb_q, rc_q;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] zhigh_q, zlow_q;
  logic              done_q;

  logic              accept;
  logic [SEL_W-1:0]  src_sel;
  logic [DATA_W-1:0] src_val;
  logic [DATA_W-1:0] dbg_val;
  logic [DATA_W-1:0] bus_c;
  logic [2*DATA_W-1:0] alu_c;
  logic [DATA_W-1:0] wr_data;
  logic [NUM_REGS-1:0] wr_en;

  // Start is only looked at in IDLE, so a request while busy is dropped.
  assign accept = (state_q == IDLE) && start;

  // State register; clr abandons any operation in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one step per edge once an operation is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = T3;
      T3:      state_d = T4;
      T4:      state_d = T5;
      T5:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture opcode and register selects on the accepting edge only.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      op_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rc_q <= '0;
    end else if (accept) begin
      op_q <= op;
      ra_q <= ra;
      rb_q <= rb;
      rc_q <= rc;
    end
  end

  // Source register read port: Ra in T3, Rb otherwise. Selects that do not
  // name an implemented register read as zero.
  assign src_sel = (state_q == T3) ? ra_q : rb_q;

  always_comb begin
    src_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (src_sel == SEL_W'(i)) src_val = regs_q[i];
    end
  end

  // Debug read port, same out-of-range rule as the source port.
  always_comb begin
    dbg_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel == SEL_W'(i)) dbg_val = regs_q[i];
    end
  end

  // Single bus driver chosen by the sequencer step.
  always_comb begin
    bus_c = '0;
    case (state_q)
      IDLE:    bus_c = '0;
      T3:      bus_c = src_val;
      T4:      bus_c = src_val;
      T5:      bus_c = zlow_q;
      default: bus_c = '0;
    endcase
  end

  // ALU produces a double-width result; logic ops and ADD zero-extend,
  // so ADD's carry-out lands in bit 0 of the high half.
  always_comb begin
    alu_c = '0;
    case (op_q)
      OP_AND:  alu_c = {{DATA_W{1'b0}}, y_q & bus_c};
      OP_OR:   alu_c = {{DATA_W{1'b0}}, y_q | bus_c};
      OP_ADD:  alu_c = {{DATA_W{1'b0}}, y_q} + {{DATA_W{1'b0}}, bus_c};
      default: alu_c = {{DATA_W{1'b0}}, y_q} * {{DATA_W{1'b0}}, bus_c};
    endcase
  end

  // Y holds the first operand taken from the bus in T3.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      y_q <= '0;
    end else if (state_q == T3) begin
      y_q <= bus_c;
    end
  end

  // Z captures the ALU result at the end of T4.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      zhigh_q <= '0;
      zlow_q  <= '0;
    end else if (state_q == T4) begin
      zhigh_q <= alu_c[2*DATA_W-1:DATA_W];
      zlow_q  <= alu_c[DATA_W-1:0];
    end
  end

  // done is high for the single cycle following the Rc write.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == T5);
    end
  end

  // The T5 write and the preload are mutually exclusive by state, so one
  // shared write-data mux suffices.
  assign wr_data = (state_q == T5) ? bus_c : load_data;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign wr_en[gi] = ((state_q == T5) && (rc_q == SEL_W'(gi))) ||
                         ((state_q == IDLE) && load_en && (load_sel == SEL_W'(gi)));

      // One general register; written by the sequencer or the preload port.
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          regs_q[gi] <= '0;
        end else if (wr_en[gi]) begin
          regs_q[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = dbg_val;
  assign bus_out = bus_c;
  assign zhigh   = zhigh_q;
  assign zlow    = zlow_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Bench for bus_datapath_seq: directed scenarios plus randomized operations
// compared with an arithmetic reference model of the register file.
module tb_bus_datapath_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  ra, rb, rc;
  logic        load_en;
  logic [3:0]  load_sel;
  logic [31:0] load_data;
  logic [3:0]  rd_sel;
  logic [31:0] rd_data, bus_out, zhigh, zlow;
  logic        busy, done;

  // Second instance with fewer registers than the select width can address.
  logic        s_start;
  logic [1:0]  s_op;
  logic [3:0]  s_ra, s_rb, s_rc;
  logic        s_load_en;
  logic [3:0]  s_load_sel;
  logic [31:0] s_load_data;
  logic [3:0]  s_rd_sel;
  logic [31:0] s_rd_data, s_bus_out, s_zhigh, s_zlow;
  logic        s_busy, s_done;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_r  [16];
  logic [31:0] sm_r [8];

  always #5 clk = ~clk;

  bus_datapath_seq #(.DATA_W(32), .NUM_REGS(16), .SEL_W(4)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .load_en(load_en), .load_sel(load_sel), .load_data(load_data),
    .rd_sel(rd_sel), .rd_data(rd_data), .bus_out(bus_out),
    .zhigh(zhigh), .zlow(zlow), .busy(busy), .done(done)
  );

  bus_datapath_seq #(.DATA_W(32), .NUM_REGS(8), .SEL_W(4)) dut_small (
    .clk(clk), .clr(clr), .start(s_start), .op(s_op), .ra(s_ra), .rb(s_rb), .rc(s_rc),
    .load_en(s_load_en), .load_sel(s_load_sel), .load_data(s_load_data),
    .rd_sel(s_rd_sel), .rd_data(s_rd_data), .bus_out(s_bus_out),
    .zhigh(s_zhigh), .zlow(s_zlow), .busy(s_busy), .done(s_done)
  );

  // Reference result of one operation, straight from the opcode meaning.
  function automatic logic [63:0] ref_alu(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      2'd0:    return {32'd0, a & b};
      2'd1:    return {32'd0, a | b};
      2'd2:    return 64'(a) + 64'(b);
      default: return 64'(a) * 64'(b);
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input int sel, input logic [31:0] d);
    load_en = 1'b1; load_sel = 4'(sel); load_data = d;
    tick();
    load_en = 1'b0;
    m_r[sel] = d;
  endtask

  // Runs one operation from IDLE, checking every step against the model.
  task automatic run_op(input logic [1:0] o, input int a_sel, input int b_sel, input int c_sel,
                        input bit with_load, input int l_sel, input logic [31:0] l_data);
    logic [31:0] a, b;
    logic [63:0] res;
    if (with_load) begin
      load_en = 1'b1; load_sel = 4'(l_sel); load_data = l_data;
      m_r[l_sel] = l_data;
    end
    a = m_r[a_sel];
    b = m_r[b_sel];
    res = ref_alu(o, a, b);
    op = o; ra = 4'(a_sel); rb = 4'(b_sel); rc = 4'(c_sel); start = 1'b1;
    tick();
    start = 1'b0; load_en = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t3_busy got %b want 1", busy); end
    n_vec++; if (bus_out !== a) begin n_err++; $display("FAIL t3_bus got %h want %h", bus_out, a); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL t3_done got %b want 0", done); end
    tick();
    n_vec++; if (bus_out !== b) begin n_err++; $display("FAIL t4_bus got %h want %h", bus_out, b); end
    tick();
    n_vec++; if (bus_out !== res[31:0]) begin n_err++; $display("FAIL t5_bus got %h want %h", bus_out, res[31:0]); end
    n_vec++; if (zhigh !== res[63:32]) begin n_err++; $display("FAIL zhigh got %h want %h", zhigh, res[63:32]); end
    n_vec++; if (zlow !== res[31:0]) begin n_err++; $display("FAIL zlow got %h want %h", zlow, res[31:0]); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t5_busy got %b want 1", busy); end
    tick();
    m_r[c_sel] = res[31:0];
    rd_sel = 4'(c_sel);
    #1;
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL done_pulse got %b want 1", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", busy); end
    n_vec++; if (rd_data !== res[31:0]) begin n_err++; $display("FAIL rc_write R%0d got %h want %h", c_sel, rd_data, res[31:0]); end
    tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_fall got %b want 0", done); end
    $display("op=%0d R%0d(%h),R%0d(%h) -> R%0d = %h zhigh=%h", o, a_sel, a, b_sel, b, c_sel, res[31:0], res[63:32]);
  endtask

  task automatic test_reset;
    clr = 1'b1;
    tick();
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
    n_vec++; if (zhigh !== 32'd0 || zlow !== 32'd0) begin n_err++; $display("FAIL rst_z got %h_%h want 0", zhigh, zlow); end
    n_vec++; if (bus_out !== 32'd0) begin n_err++; $display("FAIL rst_bus got %h want 0", bus_out); end
    for (int i = 0; i < 16; i++) begin
      rd_sel = 4'(i);
      #1;
      n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL rst_reg R%0d got %h want 0", i, rd_data); end
    end
    clr = 1'b0;
    for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
    tick();
    $display("reset applied");
  endtask

  task automatic test_alu_ops;
    do_load(2, 32'h22);
    do_load(4, 32'h24);
    run_op(2'd0, 2, 4, 5, 1'b0, 0, 32'd0);
    run_op(2'd2, 2, 4, 6, 1'b0, 0, 32'd0);
    do_load(1, 32'hFFFF_FFFF);
    do_load(3, 32'h1);
    run_op(2'd2, 1, 3, 7, 1'b0, 0, 32'd0);
    do_load(3, 32'h2);
    run_op(2'd3, 1, 3, 8, 1'b0, 0, 32'd0);
    run_op(2'd1, 0, 0, 0, 1'b0, 0, 32'd0);
    run_op(2'd2, 5, 5, 5, 1'b0, 0, 32'd0);
  endtask

  task automatic test_busy_ignore;
    do_load(2, 32'h22);
    do_load(4, 32'h24);
    do_load(9, 32'h99);
    op = 2'd0; ra = 4'd2; rb = 4'd4; rc = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; load_en = 1'b1; load_sel = 4'd9; load_data = 32'h55;
    op = 2'd3; ra = 4'd9; rb = 4'd9; rc = 4'd9;
    tick();
    start = 1'b0; load_en = 1'b0;
    n_vec++; if (bus_out !== 32'h20) begin n_err++; $display("FAIL ign_t5_bus got %h want 00000020", bus_out); end
    tick();
    m_r[5] = 32'h20;
    rd_sel = 4'd5; #1;
    n_vec++; if (rd_data !== 32'h20) begin n_err++; $display("FAIL ign_r5 got %h want 00000020", rd_data); end
    rd_sel = 4'd9; #1;
    n_vec++; if (rd_data !== 32'h99) begin n_err++; $display("FAIL ign_r9 got %h want 00000099", rd_data); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_not_queued got %b want 0", busy); end
    $display("start/load during T4 ignored, R5=%h", m_r[5]);
    run_op(2'd1, 9, 9, 10, 1'b1, 9, 32'h55);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_res;
    bit exp_busy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit exp_done [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_load(2, $urandom);
    do_load(4, $urandom);
    exp_res = ref_alu(2'd2, m_r[2], m_r[4]);
    op = 2'd2; ra = 4'd2; rb = 4'd4; rc = 4'd11; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 6) start = 1'b0;
      n_vec++; if (busy !== exp_busy[i]) begin n_err++; $display("FAIL b2b_busy[%0d] got %b want %b", i, busy, exp_busy[i]); end
      n_vec++; if (done !== exp_done[i]) begin n_err++; $display("FAIL b2b_done[%0d] got %b want %b", i, done, exp_done[i]); end
    end
    m_r[11] = exp_res;
    rd_sel = 4'd11; #1;
    n_vec++; if (rd_data !== exp_res) begin n_err++; $display("FAIL b2b_r11 got %h want %h", rd_data, exp_res); end
    tick();
    $display("back-to-back ADD x2 -> R11 = %h", exp_res);
  endtask

  task automatic test_random;
    for (int k = 0; k < 24; k++) begin
      int a_sel, b_sel, c_sel;
      logic [1:0] o;
      a_sel = $urandom_range(0, 15);
      b_sel = $urandom_range(0, 15);
      c_sel = $urandom_range(0, 15);
      o = 2'($urandom_range(0, 3));
      do_load(a_sel, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
      if ($urandom_range(0, 1) == 1) do_load(b_sel, $urandom);
      run_op(o, a_sel, b_sel, c_sel, 1'b0, 0, 32'd0);
    end
  endtask

  task automatic test_mid_op_reset;
    do_load(5, 32'h77);
    op = 2'd2; ra = 4'd1; rb = 4'd3; rc = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clr = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_busy got %b want 0", busy); end
    rd_sel = 4'd5; #1;
    n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL clr_r5 got %h want 0", rd_data); end
    tick();
    clr = 1'b0;
    for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
    for (int i = 0; i < 8; i++) sm_r[i] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL clr_quiet[%0d] got done=%b busy=%b want 0 0", i, done, busy); end
    end
    #1;
    n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL clr_r5_after got %h want 0", rd_data); end
    $display("reset between T4 and T5 abandoned op to R5");
  endtask

  task automatic small_op(input logic [1:0] o, input int a_sel, input int b_sel, input int c_sel);
    logic [31:0] a, b;
    logic [63:0] res;
    a = (a_sel < 8) ? sm_r[a_sel] : 32'd0;
    b = (b_sel < 8) ? sm_r[b_sel] : 32'd0;
    res = ref_alu(o, a, b);
    s_op = o; s_ra = 4'(a_sel); s_rb = 4'(b_sel); s_rc = 4'(c_sel); s_start = 1'b1;
    tick();
    s_start = 1'b0;
    n_vec++; if (s_busy !== 1'b1 || s_bus_out !== a) begin n_err++; $display("FAIL small_t3 got busy=%b bus=%h want 1 %h", s_busy, s_bus_out, a); end
    tick();
    tick();
    n_vec++; if (s_zhigh !== res[63:32] || s_zlow !== res[31:0]) begin n_err++; $display("FAIL small_z got %h_%h want %h", s_zhigh, s_zlow, res); end
    tick();
    n_vec++; if (s_done !== 1'b1) begin n_err++; $display("FAIL small_done got %b want 1", s_done); end
    if (c_sel < 8) sm_r[c_sel] = res[31:0];
    tick();
    $display("small op=%0d R%0d,R%0d -> R%0d = %h", o, a_sel, b_sel, c_sel, res[31:0]);
  endtask

  task automatic test_out_of_range;
    for (int i = 0; i < 8; i++) begin
      s_load_en = 1'b1; s_load_sel = 4'(i); s_load_data = 32'h100 + 32'(i) * 32'h11;
      tick();
      sm_r[i] = 32'h100 + 32'(i) * 32'h11;
    end
    s_load_sel = 4'd12; s_load_data = 32'hDEAD_BEEF;
    tick();
    s_load_en = 1'b0;
    small_op(2'd2, 1, 2, 13);
    small_op(2'd1, 12, 3, 4);
    for (int i = 0; i < 8; i++) begin
      s_rd_sel = 4'(i); #1;
      n_vec++; if (s_rd_data !== sm_r[i]) begin n_err++; $display("FAIL small_reg R%0d got %h want %h", i, s_rd_data, sm_r[i]); end
    end
    s_rd_sel = 4'd12; #1;
    n_vec++; if (s_rd_data !== 32'd0) begin n_err++; $display("FAIL small_rd12 got %h want 0", s_rd_data); end
    tick();
    $display("out-of-range selects on 8-register instance");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; start = 1'b0; op = 2'd0; ra = '0; rb = '0; rc = '0;
    load_en = 1'b0; load_sel = '0; load_data = '0; rd_sel = '0;
    s_start = 1'b0; s_op = 2'd0; s_ra = '0; s_rb = '0; s_rc = '0;
    s_load_en = 1'b0; s_load_sel = '0; s_load_data = '0; s_rd_sel = '0;
    for (int i = 0; i < 8; i++) sm_r[i] = 32'd0;
    @(negedge clk);
    test_reset();
    test_alu_ops();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_mid_op_reset();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_datapath_seq.md
Name: bus_datapath_seq

Overview:
Parametrised successor to the hand-driven bus datapath. It holds a register file, Y and Z (high/low) registers, a small ALU, and one shared internal bus. An internal T3-T5 step sequencer runs "op Rc, Ra, Rb" on its own after a start handshake, so the bench no longer drives each Rxout/Rxin strobe. A direct load port preloads registers and replaces the MDR load phases.

Parameters:
DATA_W, 32, width of registers, bus, Y and each Z half
NUM_REGS, 16, number of general registers R0..R(NUM_REGS-1)
SEL_W, 4, register select width (must satisfy 2**SEL_W >= NUM_REGS)

Ports:
clk  in  1  rising-edge clock
clr  in  1  asynchronous active-high reset
start  in  1  request an operation; sampled only in IDLE
op  in  2  00 AND, 01 OR, 10 ADD, 11 MUL (unsigned)
ra  in  SEL_W  first source register
rb  in  SEL_W  second source register
rc  in  SEL_W  destination register
load_en  in  1  preload request; honoured only in IDLE
load_sel  in  SEL_W  preload destination register
load_data  in  DATA_W  preload value
rd_sel  in  SEL_W  debug read select
rd_data  out  DATA_W  combinational read of register rd_sel
bus_out  out  DATA_W  current internal bus value
zhigh  out  DATA_W  Z high half
zlow  out  DATA_W  Z low half
busy  out  1  high in T3, T4, T5
done  out  1  one-cycle pulse after the Rc write

Behaviour:
- Reset (clr=1, asynchronous), effective immediately, including mid-operation:
  - all registers, Y, zhigh and zlow = 0
  - state = IDLE, busy = 0, done = 0
  - the in-flight operation is abandoned with no write to Rc
- States and transitions:
  - IDLE -> T3 when start=1 at a rising edge; op, ra, rb and rc are latched at that edge
  - T3 -> T4 -> T5 -> IDLE on each following edge unconditionally
- Bus source by state:
  - IDLE: 0
  - T3: R[ra]
  - T4: R[rb]
  - T5: zlow
  - There is exactly one bus driver per state, so there is no multi-driver case.
- Register updates:
  - T3 edge: Y <= bus.
  - T4 edge: Z <= ALU(Y, bus), which is 2*DATA_W wide.
    - AND/OR: zhigh = 0.
    - ADD: the result is zero-extended, so zhigh = carry-out in bit 0.
    - MUL: full unsigned product.
  - T5 edge: R[rc] <= bus (zlow); done <= 1 for exactly one cycle while the state returns to IDLE.
- Latency: if start is sampled at edge N, R[rc] updates and done rises at edge N+3; done falls at edge N+4.
- start while busy: ignored, not queued; the latched operands are unaffected.
- start asserted continuously: after done the next operation is accepted at the edge where done rises is NOT possible, because the state is in T5 at that edge. Acceptance happens at edge N+4 (from IDLE), so back-to-back throughput is one operation per 4 cycles.
- load_en in IDLE: R[load_sel] <= load_data at the edge.
- load_en with start in the same IDLE cycle: both take effect. T3 reads the newly loaded value when ra = load_sel.
- load_en while busy: ignored.
- Out-of-range select (index >= NUM_REGS):
  - writes (rc, load_sel) are dropped
  - reads (ra, rb, rd_sel) return 0
- ra = rb or rc = ra/rb: legal. Sources are read in T3/T4 before the T5 write.
- R0 is an ordinary register with no hardwired zero.

Test Plan:
- Preload R2=0x22, R4=0x24; start op=AND ra=2 rb=4 rc=5 -> bus_out 0x22 in T3, 0x24 in T4, 0x20 in T5; R5=0x00000020 and done pulse at edge N+3; busy high for 3 cycles.
- Same preloads, op=ADD rc=6 -> R6=0x46, zhigh=0. Then preload R1=0xFFFFFFFF, R3=0x1, ADD ra=1 rb=3 rc=7 -> R7=0, zhigh=1.
- R1=0xFFFFFFFF, R3=0x2, op=MUL rc=8 -> zhigh=0x00000001, zlow=0xFFFFFFFE, R8=0xFFFFFFFE.
- Pulse start and load_en (load_sel=9, load_data=0x55) during T4 -> neither takes effect, and R9 is unchanged. Then load_en+start together in IDLE with ra=rb=9, op=OR, rc=10 -> R10=0x55.
- Assert clr between the T4 and T5 edges of an op with rc=5 -> busy=0, done never pulses, and R5 reads 0 via rd_sel=5.
- With NUM_REGS=8, SEL_W=4: load_sel=12 leaves all registers unchanged, and rd_sel=12 returns 0.
